// File: rtl/mu0_host_if.sv
// Host debug memory-access port of the MU0 run controller.
// Handshake: the host raises host_req with host_we/host_addr/host_wdata stable and holds it
// until host_ack; host_ack is a one-cycle pulse (host_rdata valid with it) and the host drops
// host_req in that ack cycle. Requests are only served while the core is halted or stopped.
interface mu0_host_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/mu0_run_ctrl.sv
// Run/debug controller for the MU0 core: gates the core clock enable for run/halt/step/
// breakpoint/STP-stop, lends the memory port to the host while halted, counts cycles and fetches.
module mu0_run_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_stop,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              cpu_en,
  input  logic              cpu_fetch,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  mu0_host_if.slave         host,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    S_HALT    = 2'd0,
    S_RUN     = 2'd1,
    S_STEP    = 2'd2,
    S_STOPPED = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_skip_bp;
  logic              r_stop_pend;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_host_rdata;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_instr_cnt;

  logic w_cpu_en;
  logic w_bp_hit;
  logic w_stp_fetch;
  logic w_host_grant;
  logic w_halted;

  assign w_bp_hit     = bp_en & cpu_fetch & (cpu_pc == bp_addr) & ~r_skip_bp;
  assign w_stp_fetch  = cpu_fetch & (mem_rdata[DATA_W-1 -: 4] == 4'h7);
  assign w_halted     = (r_state == S_HALT) || (r_state == S_STOPPED);
  // r_host_ack masks the ack cycle so a late-dropped request is not served twice.
  assign w_host_grant = w_halted & host.host_req & ~r_host_ack;

  // Enable is kept apart from next-state so it never depends on memory read data.
  always_comb begin
    w_cpu_en = 1'b0;
    case (r_state)
      S_RUN:   w_cpu_en = ~w_bp_hit & ~(r_stop_pend & cpu_fetch);
      S_STEP:  w_cpu_en = 1'b1;
      default: w_cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HALT: begin
        if (cmd_run)       w_next = S_RUN;
        else if (cmd_step) w_next = S_STEP;
      end
      S_RUN: begin
        if (!w_cpu_en)        w_next = S_HALT;
        else if (w_stp_fetch) w_next = S_STOPPED;
      end
      S_STEP: begin
        // MU0 alternates fetch/execute, so an enabled execute always ends the step.
        if (w_stp_fetch)     w_next = S_STOPPED;
        else if (!cpu_fetch) w_next = S_HALT;
      end
      S_STOPPED: w_next = S_STOPPED;
      default:   w_next = S_HALT;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_dout;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (w_cpu_en) begin
      mem_rd = cpu_rd;
      mem_wr = cpu_wr;
    end else if (w_host_grant) begin
      mem_addr  = host.host_addr;
      mem_wdata = host.host_wdata;
      mem_rd    = ~host.host_we;
      mem_wr    = host.host_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_HALT;
      r_skip_bp    <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
    end else begin
      r_state     <= w_next;
      r_stop_pend <= (r_state == S_RUN) && (w_next == S_RUN) && (r_stop_pend || cmd_stop);
      if (r_state == S_HALT && cmd_run)
        r_skip_bp <= 1'b1;
      else if (w_cpu_en && cpu_fetch)
        r_skip_bp <= 1'b0;
      r_host_ack <= w_host_grant;
      if (w_host_grant && !host.host_we)
        r_host_rdata <= mem_rdata;
      if (w_cpu_en) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        if (cpu_fetch)
          r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
    end
  end

  assign cpu_en          = w_cpu_en;
  assign status          = r_state;
  assign host.host_ack   = r_host_ack;
  assign host.host_rdata = r_host_rdata;
  assign cycle_count     = r_cycle_cnt;
  assign instr_count     = r_instr_cnt;

endmodule
